wsn_rx_deframer: RTL and testbench



---
 rtl/wsn_rx_deframer_if.sv | 12 +
 rtl/wsn_rx_deframer.sv | 173 +++++++++++++++++
 tb/tb_wsn_rx_deframer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wsn_rx_deframer_if.sv
// Byte stream from the radio deframer to the CPU-side peripheral logic.
// A byte transfers on a clock edge where data_valid & data_ready are both high.
// data_out holds its value while data_valid is high and not accepted, unless a
// newer byte overwrites it.
interface wsn_rx_deframer_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/wsn_rx_deframer.sv
// Radio link receive deframer: recovers bit timing, hunts for the sync word,
// then extracts the length, payload and CRC-8 bytes of each frame.
module wsn_rx_deframer #(
  parameter int          BIT_PER   = 16,
  parameter logic [15:0] SYNC_WORD = 16'hD391,
  parameter int          MAX_LEN   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               antena_in,
  wsn_rx_deframer_if.master  rx_bus,
  output logic               frame_start,
  output logic               frame_done,
  output logic               crc_ok,
  output logic               len_err,
  output logic               overrun,
  output logic [1:0]         state_dbg
);

  localparam int            PW       = $clog2(BIT_PER);
  localparam logic [PW-1:0] PH_LAST  = PW'(BIT_PER - 1);
  localparam logic [PW-1:0] PH_SAMP  = PW'(BIT_PER / 2 - 1);
  localparam logic [7:0]    MAX_LEN8 = 8'(MAX_LEN);

  typedef enum logic [1:0] {S_HUNT = 2'd0, S_LEN = 2'd1, S_PAYLOAD = 2'd2, S_CRC = 2'd3} state_t;
  state_t state, state_nxt;

  logic          rx_m, rx_s, rx_d;
  logic [PW-1:0] phase;
  logic [15:0]   sr;
  logic [2:0]    bit_cnt;
  logic [7:0]    len, byte_cnt, crc;

  logic          bit_ev, byte_done;
  logic [15:0]   sr_shift;
  logic [7:0]    rx_byte;
  logic          sync_hit, len_bad, len_good, load_byte, crc_done;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b0;
      rx_s <= 1'b0;
      rx_d <= 1'b0;
    end else begin
      rx_m <= antena_in;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // Edges on the synchronised line re-centre the sampling point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase <= '0;
    else if (!en || (rx_s != rx_d) || (phase == PH_LAST)) phase <= '0;
    else phase <= phase + 1'b1;
  end

  assign bit_ev    = en && (phase == PH_SAMP);
  assign sr_shift  = {sr[14:0], rx_s};
  assign rx_byte   = sr_shift[7:0];
  assign byte_done = bit_ev && (bit_cnt == 3'd7);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) state_nxt = S_HUNT;
    else begin
      case (state)
        S_HUNT:    if (bit_ev && (sr_shift == SYNC_WORD)) state_nxt = S_LEN;
        S_LEN:     if (byte_done) state_nxt = ((rx_byte == 8'd0) || (rx_byte > MAX_LEN8)) ? S_HUNT : S_PAYLOAD;
        S_PAYLOAD: if (byte_done && ((byte_cnt + 8'd1) == len)) state_nxt = S_CRC;
        S_CRC:     if (byte_done) state_nxt = S_HUNT;
        default:   state_nxt = S_HUNT;
      endcase
    end
  end

  always_comb begin
    sync_hit  = 1'b0;
    len_bad   = 1'b0;
    len_good  = 1'b0;
    load_byte = 1'b0;
    crc_done  = 1'b0;
    case (state)
      S_HUNT:    sync_hit  = bit_ev && (sr_shift == SYNC_WORD);
      S_LEN: begin
        len_bad  = byte_done && ((rx_byte == 8'd0) || (rx_byte > MAX_LEN8));
        len_good = byte_done && !((rx_byte == 8'd0) || (rx_byte > MAX_LEN8));
      end
      S_PAYLOAD: load_byte = byte_done;
      S_CRC:     crc_done  = byte_done;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr       <= '0;
      bit_cnt  <= '0;
      len      <= '0;
      byte_cnt <= '0;
      crc      <= '0;
      crc_ok   <= 1'b0;
    end else if (!en) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      if (len_bad || crc_done) sr <= '0;
      else if (bit_ev)         sr <= sr_shift;
      // The bit counter only runs inside a frame; it wraps naturally every byte.
      if (state == S_HUNT) bit_cnt <= '0;
      else if (bit_ev)     bit_cnt <= bit_cnt + 3'd1;
      if (sync_hit) begin
        crc      <= 8'h00;
        crc_ok   <= 1'b0;
        byte_cnt <= '0;
      end
      if (len_good || len_bad) begin
        len <= rx_byte;
        crc <= crc8_step(crc, rx_byte);
      end
      if (load_byte) begin
        crc      <= crc8_step(crc, rx_byte);
        byte_cnt <= byte_cnt + 8'd1;
      end
      if (crc_done) crc_ok <= (rx_byte == crc);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      frame_start <= sync_hit;
      frame_done  <= crc_done;
      len_err     <= len_bad;
    end
  end

  // A new byte always wins over an acceptance in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_bus.data_out   <= '0;
      rx_bus.data_valid <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      if (load_byte) begin
        rx_bus.data_out   <= rx_byte;
        rx_bus.data_valid <= 1'b1;
      end else if (rx_bus.data_valid && rx_bus.data_ready) begin
        rx_bus.data_valid <= 1'b0;
      end
      if (!en) overrun <= 1'b0;
      else if (load_byte && rx_bus.data_valid && !rx_bus.data_ready) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wsn_rx_deframer.sv
// Bench for wsn_rx_deframer: serialises frames onto antena_in and checks the
// received bytes, pulses and flags against a frame-level reference model.
module tb_wsn_rx_deframer;

  localparam int BIT_PER = 16;
  localparam int MAX_LEN = 64;

  logic       clk = 1'b0;
  logic       reset, en, antena_in;
  logic       frame_start, frame_done, crc_ok, len_err, overrun;
  logic [1:0] state_dbg;

  wsn_rx_deframer_if bus ();

  wsn_rx_deframer #(.BIT_PER(BIT_PER), .SYNC_WORD(16'hD391), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .en(en), .antena_in(antena_in), .rx_bus(bus),
    .frame_start(frame_start), .frame_done(frame_done), .crc_ok(crc_ok),
    .len_err(len_err), .overrun(overrun), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] got_q[$];
  int   n_start = 0, n_done = 0, n_lenerr = 0;
  logic last_crc_ok = 1'b0;

  // Capture pulses and accepted bytes away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_start) n_start <= n_start + 1;
      if (len_err)     n_lenerr <= n_lenerr + 1;
      if (frame_done) begin
        n_done      <= n_done + 1;
        last_crc_ok <= crc_ok;
      end
      if (bus.data_valid && bus.data_ready) got_q.push_back(bus.data_out);
    end
  end

  // Reference CRC-8 (poly 0x07), computed bit-serially as polynomial division.
  function automatic logic [7:0] crc_model(input logic [7:0] msg[$]);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    foreach (msg[i])
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ msg[i][b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    return c;
  endfunction

  task automatic build_frame(input logic [7:0] pl[$], input bit flip, output logic [7:0] fr[$]);
    logic [7:0] c;
    fr = {};
    fr.push_back(8'(pl.size()));
    foreach (pl[i]) fr.push_back(pl[i]);
    c = crc_model(fr);
    fr.push_back(flip ? (c ^ 8'h01) : c);
  endtask

  function automatic int max_run(input logic [7:0] fr[$]);
    logic bits[$];
    logic [15:0] sw;
    int run, best;
    sw = 16'hD391;
    for (int i = 15; i >= 0; i--) bits.push_back(sw[i]);
    foreach (fr[j]) for (int i = 7; i >= 0; i--) bits.push_back(fr[j][i]);
    run = 1; best = 1;
    for (int i = 1; i < bits.size(); i++) begin
      run  = (bits[i] == bits[i-1]) ? run + 1 : 1;
      best = (run > best) ? run : best;
    end
    return best;
  endfunction

  task automatic send_bit(input logic b, input int per, input bit rnd);
    antena_in = b;
    for (int k = 0; k < per; k++) begin
      if (rnd) bus.data_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input int per, input bit rnd);
    logic [15:0] sw;
    sw = 16'hD391;
    for (int i = 15; i >= 0; i--) send_bit(sw[i], per, rnd);
    foreach (fr[j]) for (int i = 7; i >= 0; i--) send_bit(fr[j][i], per, rnd);
    if (rnd) bus.data_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(1'b0, per, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; antena_in = 1'b0; bus.data_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.data_out, bus.data_valid, frame_start, frame_done, crc_ok, len_err, overrun} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want all zero",
               {bus.data_out, bus.data_valid, frame_start, frame_done, crc_ok, len_err, overrun});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_frame(input string name, input logic [7:0] pl[$], input int per,
                            input bit flip, input bit rnd);
    logic [7:0] fr[$];
    int s0, d0, l0, g0;
    s0 = n_start; d0 = n_done; l0 = n_lenerr; g0 = got_q.size();
    build_frame(pl, flip, fr);
    send_frame(fr, per, rnd);
    @(negedge clk);
    total++;
    if (n_start - s0 != 1) begin bad++; $display("FAIL %s start: got %0d pulses want 1", name, n_start - s0); end
    total++;
    if (n_done - d0 != 1) begin bad++; $display("FAIL %s done: got %0d pulses want 1", name, n_done - d0); end
    total++;
    if (last_crc_ok !== !flip) begin bad++; $display("FAIL %s crc_ok: got %b want %b", name, last_crc_ok, !flip); end
    total++;
    if (n_lenerr != l0) begin bad++; $display("FAIL %s len_err: got %0d pulses want 0", name, n_lenerr - l0); end
    total++;
    if (got_q.size() - g0 != pl.size()) begin
      bad++; $display("FAIL %s byte_count: got %0d want %0d", name, got_q.size() - g0, pl.size());
    end else begin
      foreach (pl[i]) begin
        total++;
        if (got_q[g0 + i] !== pl[i]) begin
          bad++; $display("FAIL %s byte%0d: got %h want %h", name, i, got_q[g0 + i], pl[i]);
        end
      end
    end
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL %s overrun: got %b want 0", name, overrun); end
  endtask

  task automatic test_len_err();
    logic [7:0] fr[$];
    logic [7:0] pl[$];
    int s0, l0, g0, d0;
    s0 = n_start; l0 = n_lenerr; g0 = got_q.size(); d0 = n_done;
    fr = {8'h00};
    send_frame(fr, BIT_PER, 1'b0);
    fr = {8'(MAX_LEN + 1)};
    send_frame(fr, BIT_PER, 1'b0);
    @(negedge clk);
    total++;
    if (n_lenerr - l0 != 2) begin bad++; $display("FAIL len_err_pulses: got %0d want 2", n_lenerr - l0); end
    total++;
    if (n_start - s0 != 2) begin bad++; $display("FAIL len_err_starts: got %0d want 2", n_start - s0); end
    total++;
    if ((got_q.size() != g0) || (n_done != d0)) begin
      bad++; $display("FAIL len_err_quiet: got %0d bytes %0d done want 0 0", got_q.size() - g0, n_done - d0);
    end
    pl = {};
    for (int i = 0; i < 4; i++) pl.push_back(8'($urandom_range(0, 255)));
    test_frame("after_len_err", pl, BIT_PER, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [7:0] fr[$];
    logic [7:0] pl[$];
    int g0;
    g0 = got_q.size();
    bus.data_ready = 1'b0;
    pl = {8'h11, 8'h22};
    build_frame(pl, 1'b0, fr);
    send_frame(fr, BIT_PER, 1'b0);
    @(negedge clk);
    total++;
    if ({bus.data_valid, bus.data_out, overrun} !== {1'b1, 8'h22, 1'b1}) begin
      bad++; $display("FAIL bp_hold: got valid=%b data=%h overrun=%b want 1 22 1", bus.data_valid, bus.data_out, overrun);
    end
    @(posedge clk); #1;
    bus.data_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ((got_q.size() != g0 + 1) || (got_q[got_q.size() - 1] !== 8'h22)) begin
      bad++; $display("FAIL bp_consume: got %0d bytes want 1 byte 22", got_q.size() - g0);
    end
    total++;
    if ({bus.data_valid, overrun} !== 2'b01) begin
      bad++; $display("FAIL bp_after: got valid=%b overrun=%b want 0 1", bus.data_valid, overrun);
    end
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL bp_en_clear: got overrun=%b want 0", overrun); end
    @(posedge clk); #1;
    en = 1'b1;
  endtask

  task automatic test_drift();
    logic [7:0] pl[$];
    logic [7:0] fr[$];
    int per;
    for (int p = 0; p < 2; p++) begin
      per = (p == 0) ? BIT_PER - 1 : BIT_PER + 1;
      for (int t = 0; t < 500; t++) begin
        pl = {};
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom_range(0, 255)));
        build_frame(pl, 1'b0, fr);
        if (max_run(fr) <= 6) break;
      end
      test_frame((p == 0) ? "drift_15" : "drift_17", pl, per, 1'b0, 1'b0);
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] pl[$];
    for (int f = 0; f < 3; f++) begin
      pl = {};
      for (int i = 0; i < $urandom_range(1, 8); i++) pl.push_back(8'($urandom_range(0, 255)));
      test_frame("random", pl, BIT_PER, 1'b0, 1'b1);
    end
    pl = {};
    for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'($urandom_range(0, 255)));
    test_frame("max_len", pl, BIT_PER, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [7:0] fr[$];
    logic [7:0] pl[$];
    int g0, d0, waited;
    g0 = got_q.size(); d0 = n_done;
    pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    build_frame(pl, 1'b0, fr);
    fork
      send_frame(fr, BIT_PER, 1'b0);
      begin
        waited = 0;
        while ((got_q.size() < g0 + 2) && (waited < 3000)) begin
          @(posedge clk); waited++;
        end
        total++;
        if (waited >= 3000) begin bad++; $display("FAIL rst_mid_wait: got %0d bytes want 2", got_q.size() - g0); end
        #1;
        reset = 1'b1;
        #1;
        total++;
        if ({bus.data_out, bus.data_valid, frame_start, frame_done, crc_ok, len_err, overrun} !== 14'd0) begin
          bad++;
          $display("FAIL rst_mid_outputs: got %b want all zero",
                   {bus.data_out, bus.data_valid, frame_start, frame_done, crc_ok, len_err, overrun});
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
      end
    join
    @(negedge clk);
    total++;
    if ((got_q.size() != g0 + 2) || (n_done != d0)) begin
      bad++; $display("FAIL rst_mid_ignored: got %0d bytes %0d done want 2 0", got_q.size() - g0, n_done - d0);
    end
    test_frame("after_rst_mid", pl, BIT_PER, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] pl[$];
    test_reset();
    pl = {8'hA5, 8'h5A, 8'hFF};
    test_frame("single", pl, BIT_PER, 1'b0, 1'b0);
    test_frame("bad_crc", pl, BIT_PER, 1'b1, 1'b0);
    test_len_err();
    test_backpressure();
    test_drift();
    test_random_frames();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
